// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, single-outstanding imem port, one-entry
// output register to the decoder, and redirect handling with stale-response drop.
module fetch_unit #(
    parameter int unsigned     width    = 32,
    parameter logic [width-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [width-1:0] imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [width-1:0] imem_rdata,
    input  logic             redirect,
    input  logic [width-1:0] redirect_pc,
    output logic [width-1:0] instr,
    output logic [width-1:0] instr_pc,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic             fetch_fault,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [width-1:0] pc_q, pc_d;
    logic [width-1:0] instr_q, instr_d;
    logic [width-1:0] instr_pc_q, instr_pc_d;
    logic             instr_valid_q, instr_valid_d;
    logic             fetch_fault_q, fetch_fault_d;
    logic             granted;

    // Handshakes: a transfer happens on a cycle where valid and ready are both high.
    // imem: imem_req/imem_addr hold until imem_gnt; one imem_rvalid follows each grant.
    // decoder: instr_valid/instr/instr_pc hold until instr_ready; void in a redirect cycle.
    assign imem_req  = (state_q == REQ) && (!instr_valid_q || instr_ready);
    assign imem_addr = pc_q;
    assign granted   = imem_req && imem_gnt;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q && !instr_ready;
        fetch_fault_d = 1'b0;

        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (granted) state_d = WAIT;
            end
            WAIT: begin
                if (imem_rvalid) begin
                    instr_d       = imem_rdata;
                    instr_pc_d    = pc_q;
                    instr_valid_d = 1'b1;
                    pc_d          = pc_q + width'(4);
                    state_d       = REQ;
                end
            end
            DROP: begin
                if (imem_rvalid) state_d = REQ;
            end
            default: state_d = IDLE;
        endcase

        // Redirect overrides everything above, including any capture this cycle.
        if (redirect) begin
            pc_d          = {redirect_pc[width-1:2], 2'b00};
            instr_d       = instr_q;
            instr_pc_d    = instr_pc_q;
            instr_valid_d = 1'b0;
            fetch_fault_d = |redirect_pc[1:0];
            case (state_q)
                IDLE:    state_d = REQ;
                REQ:     state_d = granted ? DROP : REQ;
                WAIT:    state_d = imem_rvalid ? REQ : DROP;
                DROP:    state_d = imem_rvalid ? REQ : DROP;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            fetch_fault_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            fetch_fault_q <= fetch_fault_d;
        end
    end

    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign fetch_fault = fetch_fault_q;
    assign dbg_state   = state_q;

endmodule
